soc_gpio_bank: RTL and testbench
================================

# soc_gpio_bank

Parametrised GPIO bank for the kmakise SoC. It replaces the fixed 8-bit bidirectional pin handling at the top level with a register-mapped block that adds:
- configurable width;
- per-pin direction;
- input synchronisation and optional debounce;
- edge-triggered interrupts.

It sits between the CPU register bus and the `uio_in` / `uio_out` / `uio_oe` pad wires, or any other pin group of width `WIDTH`.

## Interface
Parameters:
- `WIDTH`, 8: number of pins (1..32).
- `SYNC_STAGES`, 2: input synchroniser depth (≥2).
- `DEB_CYCLES`, 4: consecutive stable cycles required before a debounced input changes (≥1).

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  3  register index.
- `wdata`  in  `WIDTH`  write data.
- `we`  in  1  write strobe, one cycle per write.
- `re`  in  1  read strobe.
- `rdata`  out  `WIDTH`  read data, registered.
- `pin_in`  in  `WIDTH`  raw pad inputs (asynchronous).
- `pin_out`  out  `WIDTH`  pad output values.
- `pin_oe`  out  `WIDTH`  pad output enables (1 = drive).
- `irq`  out  1  level interrupt.

## Operation
Register map (`addr`):
- 0 OUT (rw): drives `pin_out`.
- 1 DIR (rw): drives `pin_oe`.
- 2 IN (ro): filtered input value.
- 3 IRQ_EN (rw).
- 4 IRQ_RISE (rw): per-pin enable for rising-edge capture.
- 5 IRQ_FALL (rw): per-pin enable for falling-edge capture.
- 6 IRQ_STAT (r, write-1-to-clear).
- 7 DEB_EN (rw): per-pin debounce enable.

Writes to addr 2 are ignored.

Input path, per pin:
- `SYNC_STAGES` flops, then filter.
- `DEB_EN[i]`=0: filtered = synchronised value.
- `DEB_EN[i]`=1: a per-pin counter (width `clog2(DEB_CYCLES+1)`) counts cycles where the synchronised value ≠ filtered value.
  - Counter resets to 0 on any cycle where they are equal.
  - When the count reaches `DEB_CYCLES`, filtered takes the synchronised value and the counter clears.

Edge detection:
- Compares filtered with its previous-cycle value.
- A rising edge with `IRQ_RISE[i]` set, or a falling edge with `IRQ_FALL[i]` set, sets `IRQ_STAT[i]`.
- Capture is independent of `IRQ_EN`.

Status and interrupt:
- Writing 1 to a bit of `IRQ_STAT` clears it; writing 0 has no effect.
- If a set event and a W1C hit the same bit in the same cycle, set wins.
- `irq` = OR of (`IRQ_STAT` & `IRQ_EN`), registered.

Output path:
- Pins with DIR=1 are still sampled through the input path, so readback of driven pins works.

Reset (async assert, `rst_n` low):
- All registers, synchroniser flops, filtered values, edge-history flops and debounce counters go to 0.
- `pin_out`=0, `pin_oe`=0 (all pins are inputs), `rdata`=0, `irq`=0.
- Reset mid-debounce discards the count.
- Release is taken on a clock edge; no edge event is generated on the first post-reset cycle, because history equals filtered = 0.

Widths: `wdata` and `rdata` are `WIDTH` bits. Addresses outside 0..7 cannot occur (3-bit `addr`).

## Timing
- Write: `we` is sampled at edge N; the register, `pin_out` and `pin_oe` update at N, visible after edge N.
- Read: `re` is sampled at edge N; `rdata` is valid after edge N and holds until the next `re`.
  - `rdata` returns the value present before any same-cycle write.
  - Simultaneous `re` and `we` are legal.
- Input latency, debounce off: a `pin_in` change before edge N appears in IN after edge N+`SYNC_STAGES`-1.
  - `IRQ_STAT` sets one edge later.
  - `irq` rises one edge after that.
- Debounce on: add `DEB_CYCLES` edges to filtered. A glitch shorter than `DEB_CYCLES` synchronised cycles never reaches IN.
- `irq` deasserts one edge after the W1C edge, unless a new set occurs in the same cycle.

## Test plan
- **Reset:** drive `pin_in`=8'hFF and hold `rst_n` low.
  - Required: `pin_oe`=0, `pin_out`=0, `rdata`=0, `irq`=0.
  - After release, read IN = 8'hFF after 2 edges; `IRQ_STAT`=0.
- **Output/direction:** write OUT=8'hA5, DIR=8'h0F.
  - Required: `pin_out`=8'hA5 and `pin_oe`=8'h0F the cycle after each write.
  - Reading addr 0 and 1 returns the same values.
- **Rising-edge interrupt:** IRQ_RISE=8'h01, IRQ_EN=8'h01; `pin_in[0]` goes 0→1.
  - Required: `IRQ_STAT`=8'h01 and `irq`=1 within 4 edges.
  - W1C 8'h01 → `irq`=0 one edge later.
- **Set-wins collision:** time a W1C of bit 2 to the cycle in which a falling edge on bit 2 is captured (IRQ_FALL=8'h04).
  - Required: `IRQ_STAT[2]` remains 1.
- **Debounce:** DEB_EN=8'h02; toggle `pin_in[1]` high for 3 cycles, then low.
  - Required: IN[1] stays 0 and no status bit is set.
  - Hold high for 6 cycles → IN[1]=1.
- **Reset mid-operation:** assert `rst_n` low during a debounce count with `IRQ_STAT`=8'hFF.
  - Required: all outputs return to 0 immediately without a clock.
  - After release, no spurious status is set.

Source files
------------

// File: rtl/soc_gpio_bank.sv
// ============================================================================
// Module   : soc_gpio_bank
// Brief    : Register-mapped GPIO bank with synchronised, optionally debounced
//            inputs and edge-capture interrupts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module soc_gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    output logic             irq
);

    localparam int c_CNT_W = $clog2(DEB_CYCLES + 1);

    localparam logic [2:0] c_ADDR_OUT  = 3'd0;
    localparam logic [2:0] c_ADDR_DIR  = 3'd1;
    localparam logic [2:0] c_ADDR_IN   = 3'd2;
    localparam logic [2:0] c_ADDR_EN   = 3'd3;
    localparam logic [2:0] c_ADDR_RISE = 3'd4;
    localparam logic [2:0] c_ADDR_FALL = 3'd5;
    localparam logic [2:0] c_ADDR_STAT = 3'd6;
    localparam logic [2:0] c_ADDR_DEB  = 3'd7;

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_stat;
    logic [WIDTH-1:0] r_deb_en;
    logic [WIDTH-1:0] r_hist;
    logic [WIDTH-1:0] r_rdata;
    logic             r_irq;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_evt;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_rd;

    // Synchroniser chain; the last stage is the synchronised pin value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_deb
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

            logic [c_CNT_W-1:0] r_cnt;
            logic               r_deb;

            // While disabled the filter shadows the synchronised value so that
            // enabling debounce starts from the current pin level.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (!r_deb_en[i] || (w_sync[i] == r_deb)) begin
                    r_cnt <= '0;
                    r_deb <= w_sync[i];
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt <= '0;
                    r_deb <= w_sync[i];
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            assign w_deb[i] = r_deb;
        end
    endgenerate

    assign w_filt = (r_deb_en & w_deb) | (~r_deb_en & w_sync);
    assign w_evt  = (w_filt & ~r_hist & r_rise_en) | (~w_filt & r_hist & r_fall_en);
    assign w_w1c  = (we && (addr == c_ADDR_STAT)) ? wdata : '0;

    always_comb begin
        w_rd = '0;
        case (addr)
            c_ADDR_OUT:  w_rd = r_out;
            c_ADDR_DIR:  w_rd = r_dir;
            c_ADDR_IN:   w_rd = w_filt;
            c_ADDR_EN:   w_rd = r_irq_en;
            c_ADDR_RISE: w_rd = r_rise_en;
            c_ADDR_FALL: w_rd = r_fall_en;
            c_ADDR_STAT: w_rd = r_stat;
            c_ADDR_DEB:  w_rd = r_deb_en;
            default:     w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_irq_en  <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_deb_en  <= '0;
        end else if (we) begin
            case (addr)
                c_ADDR_OUT:  r_out     <= wdata;
                c_ADDR_DIR:  r_dir     <= wdata;
                c_ADDR_EN:   r_irq_en  <= wdata;
                c_ADDR_RISE: r_rise_en <= wdata;
                c_ADDR_FALL: r_fall_en <= wdata;
                c_ADDR_DEB:  r_deb_en  <= wdata;
                default:     ;
            endcase
        end
    end

    // New events are OR-ed after the clear so a coincident set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat  <= '0;
            r_hist  <= '0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_stat <= (r_stat & ~w_w1c) | w_evt;
            r_hist <= w_filt;
            r_irq  <= |(r_stat & r_irq_en);
            if (re) begin
                r_rdata <= w_rd;
            end
        end
    end

    assign rdata   = r_rdata;
    assign pin_out = r_out;
    assign pin_oe  = r_dir;
    assign irq     = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_soc_gpio_bank.sv
// ============================================================================
// Module   : tb_soc_gpio_bank
// Brief    : Self-checking bench for soc_gpio_bank with a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_soc_gpio_bank;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   addr;
    logic [W-1:0] wdata;
    logic         we;
    logic         re;
    logic [W-1:0] rdata;
    logic [W-1:0] pin_in;
    logic [W-1:0] pin_out;
    logic [W-1:0] pin_oe;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    soc_gpio_bank #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: pins pass through an S-deep delay line, then each
    // debounced pin needs DEB consecutive disagreeing samples to move.
    logic [W-1:0] m_pipe [S];
    logic [W-1:0] m_deb, m_hist, m_stat, m_out, m_dir, m_en, m_rise, m_fall, m_deben, m_rdata;
    logic         m_irq;
    int           m_run [W];

    task automatic model_reset();
        for (int s = 0; s < S; s++) m_pipe[s] = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_deb = '0; m_hist = '0; m_stat = '0; m_out = '0; m_dir = '0;
        m_en = '0; m_rise = '0; m_fall = '0; m_deben = '0; m_rdata = '0; m_irq = 1'b0;
    endtask

    function automatic logic [W-1:0] model_in();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_deben[i] ? m_deb[i] : m_pipe[S-1][i];
        return v;
    endfunction

    task automatic model_edge();
        logic [W-1:0] sync, filt, evt, clr;
        sync = m_pipe[S-1];
        filt = model_in();
        if (re) begin
            case (addr)
                3'd0: m_rdata = m_out;
                3'd1: m_rdata = m_dir;
                3'd2: m_rdata = filt;
                3'd3: m_rdata = m_en;
                3'd4: m_rdata = m_rise;
                3'd5: m_rdata = m_fall;
                3'd6: m_rdata = m_stat;
                default: m_rdata = m_deben;
            endcase
        end
        evt = '0;
        for (int i = 0; i < W; i++) begin
            if (filt[i] && !m_hist[i] && m_rise[i]) evt[i] = 1'b1;
            if (!filt[i] && m_hist[i] && m_fall[i]) evt[i] = 1'b1;
        end
        clr   = (we && addr == 3'd6) ? wdata : '0;
        m_irq = (m_stat & m_en) != '0;
        m_stat = (m_stat & ~clr) | evt;
        m_hist = filt;
        for (int i = 0; i < W; i++) begin
            if (!m_deben[i] || sync[i] == m_deb[i]) begin
                m_run[i] = 0;
                m_deb[i] = sync[i];
            end else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = sync[i];
                    m_run[i] = 0;
                end
            end
        end
        for (int s = S - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = pin_in;
        if (we) begin
            case (addr)
                3'd0: m_out   = wdata;
                3'd1: m_dir   = wdata;
                3'd3: m_en    = wdata;
                3'd4: m_rise  = wdata;
                3'd5: m_fall  = wdata;
                3'd7: m_deben = wdata;
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus(input logic w, input logic r, input logic [2:0] a, input logic [W-1:0] d);
        we = w; re = r; addr = a; wdata = d;
        step();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset();
        pin_in = 8'hFF;
        rst_n  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (pin_oe !== 8'h00) begin n_errors++; $display("FAIL reset_oe: got %h expected 00", pin_oe); end
        n_checks++; if (pin_out !== 8'h00) begin n_errors++; $display("FAIL reset_out: got %h expected 00", pin_out); end
        n_checks++; if (rdata !== 8'h00) begin n_errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst_n = 1'b1;
        step();
        step();
        bus(1'b0, 1'b1, 3'd2, '0);
        n_checks++; if (rdata !== 8'hFF || rdata !== m_rdata) begin n_errors++; $display("FAIL reset_in: got %h expected FF (model %h)", rdata, m_rdata); end
        bus(1'b0, 1'b1, 3'd6, '0);
        n_checks++; if (rdata !== 8'h00) begin n_errors++; $display("FAIL reset_stat: got %h expected 00", rdata); end
    endtask

    task automatic test_out_dir();
        bus(1'b1, 1'b0, 3'd0, 8'hA5);
        n_checks++; if (pin_out !== 8'hA5) begin n_errors++; $display("FAIL out_pin: got %h expected A5", pin_out); end
        bus(1'b1, 1'b0, 3'd1, 8'h0F);
        n_checks++; if (pin_oe !== 8'h0F) begin n_errors++; $display("FAIL dir_pin: got %h expected 0F", pin_oe); end
        bus(1'b0, 1'b1, 3'd0, '0);
        n_checks++; if (rdata !== 8'hA5) begin n_errors++; $display("FAIL out_read: got %h expected A5", rdata); end
        bus(1'b0, 1'b1, 3'd1, '0);
        n_checks++; if (rdata !== 8'h0F) begin n_errors++; $display("FAIL dir_read: got %h expected 0F", rdata); end
    endtask

    task automatic test_rise_irq();
        int k;
        pin_in = 8'h00;
        repeat (4) step();
        bus(1'b1, 1'b0, 3'd4, 8'h01);
        bus(1'b1, 1'b0, 3'd3, 8'h01);
        bus(1'b1, 1'b0, 3'd6, 8'hFF);
        step();
        pin_in = 8'h01;
        k = 0;
        while (irq !== 1'b1 && k < 4) begin
            step();
            k++;
        end
        n_checks++; if (irq !== 1'b1 || m_irq !== 1'b1) begin n_errors++; $display("FAIL rise_irq: got %b expected 1 within 4 edges (model %b)", irq, m_irq); end
        bus(1'b0, 1'b1, 3'd6, '0);
        n_checks++; if (rdata !== 8'h01) begin n_errors++; $display("FAIL rise_stat: got %h expected 01", rdata); end
        bus(1'b1, 1'b0, 3'd6, 8'h01);
        step();
        n_checks++; if (irq !== 1'b0 || m_irq !== 1'b0) begin n_errors++; $display("FAIL rise_w1c_irq: got %b expected 0", irq); end
    endtask

    task automatic test_set_wins();
        bus(1'b1, 1'b0, 3'd5, 8'h04);
        pin_in[2] = 1'b1;
        repeat (4) step();
        bus(1'b1, 1'b0, 3'd6, 8'hFF);
        pin_in[2] = 1'b0;
        step();
        step();
        bus(1'b1, 1'b0, 3'd6, 8'h04);
        bus(1'b0, 1'b1, 3'd6, '0);
        n_checks++; if (rdata[2] !== 1'b1 || rdata !== m_rdata) begin n_errors++; $display("FAIL set_wins: got %h expected bit2 set (model %h)", rdata, m_rdata); end
    endtask

    task automatic test_debounce();
        bus(1'b1, 1'b0, 3'd7, 8'h02);
        bus(1'b1, 1'b0, 3'd4, 8'h03);
        bus(1'b1, 1'b0, 3'd6, 8'hFF);
        pin_in[1] = 1'b1;
        repeat (3) step();
        pin_in[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, 1'b1, 3'd2, '0);
            n_checks++; if (rdata[1] !== 1'b0) begin n_errors++; $display("FAIL deb_glitch_in: cycle %0d got %h expected bit1 clear", i, rdata); end
        end
        bus(1'b0, 1'b1, 3'd6, '0);
        n_checks++; if (rdata !== 8'h00) begin n_errors++; $display("FAIL deb_glitch_stat: got %h expected 00", rdata); end
        pin_in[1] = 1'b1;
        repeat (6) step();
        bus(1'b0, 1'b1, 3'd2, '0);
        n_checks++; if (rdata[1] !== 1'b1 || rdata !== m_rdata) begin n_errors++; $display("FAIL deb_hold_in: got %h expected bit1 set (model %h)", rdata, m_rdata); end
        bus(1'b0, 1'b1, 3'd6, '0);
        n_checks++; if (rdata !== 8'h02) begin n_errors++; $display("FAIL deb_hold_stat: got %h expected 02", rdata); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we    = ($urandom_range(3) == 0);
            re    = $urandom_range(1);
            addr  = 3'($urandom_range(7));
            wdata = W'($urandom);
            pin_in = pin_in ^ W'($urandom & $urandom & $urandom);
            step();
            n_checks++; if (pin_out !== m_out) begin n_errors++; $display("FAIL rand_out: it %0d got %h expected %h", n, pin_out, m_out); end
            n_checks++; if (pin_oe !== m_dir) begin n_errors++; $display("FAIL rand_oe: it %0d got %h expected %h", n, pin_oe, m_dir); end
            n_checks++; if (irq !== m_irq) begin n_errors++; $display("FAIL rand_irq: it %0d got %b expected %b", n, irq, m_irq); end
            n_checks++; if (rdata !== m_rdata) begin n_errors++; $display("FAIL rand_rdata: it %0d got %h expected %h", n, rdata, m_rdata); end
        end
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus(1'b1, 1'b0, 3'd7, 8'h00);
        bus(1'b1, 1'b0, 3'd4, 8'hFF);
        bus(1'b1, 1'b0, 3'd3, 8'hFF);
        bus(1'b1, 1'b0, 3'd0, 8'h5A);
        pin_in = 8'h00;
        repeat (5) step();
        bus(1'b1, 1'b0, 3'd6, 8'hFF);
        pin_in = 8'hFF;
        repeat (4) step();
        bus(1'b0, 1'b1, 3'd6, '0);
        n_checks++; if (rdata !== 8'hFF) begin n_errors++; $display("FAIL mid_stat_pre: got %h expected FF", rdata); end
        bus(1'b1, 1'b0, 3'd7, 8'hFF);
        pin_in = 8'h00;
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (pin_out !== 8'h00) begin n_errors++; $display("FAIL mid_out: got %h expected 00", pin_out); end
        n_checks++; if (pin_oe !== 8'h00) begin n_errors++; $display("FAIL mid_oe: got %h expected 00", pin_oe); end
        n_checks++; if (rdata !== 8'h00) begin n_errors++; $display("FAIL mid_rdata: got %h expected 00", rdata); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL mid_irq: got %b expected 0", irq); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step();
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL mid_post_irq: got %b expected 0", irq); end
        bus(1'b0, 1'b1, 3'd6, '0);
        n_checks++; if (rdata !== 8'h00 || rdata !== m_rdata) begin n_errors++; $display("FAIL mid_post_stat: got %h expected 00", rdata); end
    endtask

    initial begin
        rst_n  = 1'b0;
        we     = 1'b0;
        re     = 1'b0;
        addr   = '0;
        wdata  = '0;
        pin_in = '0;
        test_reset();
        test_out_dir();
        test_rise_irq();
        test_set_wins();
        test_debounce();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
